// File: rtl/dsp_pkg.sv
// Shared sizing for the two-stage 48-bit adder.
//   WIDTH : operand / result width
//   LO_W  : width of the low pipeline slice
//   HI_W  : width of the high pipeline slice (WIDTH - LO_W)
package dsp_pkg;

  localparam int unsigned WIDTH = 48;
  localparam int unsigned LO_W  = 24;
  localparam int unsigned HI_W  = WIDTH - LO_W;

endpackage : dsp_pkg

// File: rtl/add_slice.sv
// Purely combinational N-bit unsigned adder with carry in and carry out.
// Ports:
//   a, b : N-bit addends
//   cin  : carry into bit 0
//   sum  : N-bit sum
//   cout : carry out of bit N-1
module add_slice #(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  // Zero-extend everything to N+1 bits so the carry is kept.
  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule : add_slice

// File: rtl/dsp_48add.sv
// Two-stage pipelined unsigned adder: {carryout, Out} = A + B + carryin.
// Stage 1 adds the low slice and delays the high operands; stage 2 adds the
// high slice with the registered low carry. Latency 2, throughput 1/cycle.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears every pipeline register
//   A, B     : WIDTH-bit addends
//   carryin  : carry into bit 0
//   Out      : registered WIDTH-bit sum
//   carryout : registered carry out of the top bit
module dsp_48add
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH = dsp_pkg::WIDTH,
  parameter int unsigned LO_W  = dsp_pkg::LO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  output logic [WIDTH-1:0] Out,
  output logic             carryout
);

  localparam int unsigned HI_W_L = WIDTH - LO_W;

  // Stage 1 state
  logic [LO_W-1:0]   lo_sum_q;
  logic              lo_c_q;
  logic [HI_W_L-1:0] a_hi_q;
  logic [HI_W_L-1:0] b_hi_q;

  // Stage 2 state
  logic [WIDTH-1:0]  out_q;
  logic              cout_q;

  // Combinational slice results
  logic [LO_W-1:0]   lo_sum_d;
  logic              lo_c_d;
  logic [HI_W_L-1:0] hi_sum_d;
  logic              hi_c_d;

  add_slice #(
    .N (LO_W)
  ) u_lo_slice (
    .a    (A[LO_W-1:0]),
    .b    (B[LO_W-1:0]),
    .cin  (carryin),
    .sum  (lo_sum_d),
    .cout (lo_c_d)
  );

  // High slice works on the delayed operands so it lines up with lo_c_q.
  add_slice #(
    .N (HI_W_L)
  ) u_hi_slice (
    .a    (a_hi_q),
    .b    (b_hi_q),
    .cin  (lo_c_q),
    .sum  (hi_sum_d),
    .cout (hi_c_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_q <= '0;
      lo_c_q   <= 1'b0;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      out_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      lo_sum_q <= lo_sum_d;
      lo_c_q   <= lo_c_d;
      a_hi_q   <= A[WIDTH-1:LO_W];
      b_hi_q   <= B[WIDTH-1:LO_W];
      out_q    <= {hi_sum_d, lo_sum_q};
      cout_q   <= hi_c_d;
    end
  end

  assign Out      = out_q;
  assign carryout = cout_q;

endmodule : dsp_48add

// File: tb/tb_dsp_48add.sv
// Self-checking bench for dsp_48add: reset, directed corner sums, slice
// boundary carry, back-to-back issue, mid-flight reset and a random sweep
// checked against a 49-bit reference delayed by two cycles.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dsp_48add;

  logic        clk;
  logic        rst_n;
  logic [47:0] A;
  logic [47:0] B;
  logic        carryin;
  logic [47:0] Out;
  logic        carryout;

  int total;
  int bad;

  dsp_48add dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .carryin  (carryin),
    .Out      (Out),
    .carryout (carryout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    A       = 48'hFFFF_FFFF_FFFF;
    B       = 48'hFFFF_FFFF_FFFF;
    carryin = 1'b1;
    #3;
    total++;
    if (Out !== 48'h0 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got %h/%b want 000000000000/0", Out, carryout);
    end
    step();
    total++;
    if (Out !== 48'h0 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL reset_held_edge: got %h/%b want 000000000000/0", Out, carryout);
    end
    rst_n = 1'b1;
    // First edge after release shows the cleared stage-1 contents.
    step();
    total++;
    if (Out !== 48'h0 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_edge: got %h/%b want 000000000000/0", Out, carryout);
    end
    // Second edge shows the sum sampled at the first edge.
    step();
    total++;
    if (Out !== 48'hFFFF_FFFF_FFFF || carryout !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_result: got %h/%b want ffffffffffff/1", Out, carryout);
    end
  endtask

  task automatic test_directed();
    logic [47:0] ta [4];
    logic [47:0] tb [4];
    logic        tc [4];
    logic [47:0] eo [4];
    logic        ec [4];
    ta[0] = 48'h007F_FF3C_F7D7; tb[0] = 48'hFFFF_FFFF_FFFF; tc[0] = 1'b1;
    eo[0] = 48'h007F_FF3C_F7D7; ec[0] = 1'b1;
    ta[1] = 48'hFFFF_FFFF_FFFF; tb[1] = 48'h0;              tc[1] = 1'b1;
    eo[1] = 48'h0;              ec[1] = 1'b1;
    ta[2] = 48'h0000_00FF_FFFF; tb[2] = 48'h0000_0000_0001; tc[2] = 1'b0;
    eo[2] = 48'h0000_0100_0000; ec[2] = 1'b0;
    ta[3] = 48'h1234_5678_9ABC; tb[3] = 48'h0FED_CBA9_8765; tc[3] = 1'b0;
    eo[3] = 48'h2222_2222_2221; ec[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = ta[i]; B = tb[i]; carryin = tc[i];
      step();
      // Change inputs away from the edge: must not disturb the result.
      A = 48'h5555_5555_5555; B = 48'hAAAA_AAAA_AAAA; carryin = ~tc[i];
      #2;
      A = ta[i]; B = tb[i]; carryin = tc[i];
      step();
      total++;
      if (Out !== eo[i] || carryout !== ec[i]) begin
        bad++;
        $display("FAIL directed_%0d: got %h/%b want %h/%b", i, Out, carryout, eo[i], ec[i]);
      end
      A = 48'h5555_5555_5555; B = 48'hAAAA_AAAA_AAAA; carryin = 1'b0;
      #3;
      total++;
      if (Out !== eo[i] || carryout !== ec[i]) begin
        bad++;
        $display("FAIL hold_%0d: got %h/%b want %h/%b", i, Out, carryout, eo[i], ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    A = 48'd1; B = 48'd2; carryin = 1'b0;
    step();
    A = 48'h8000_0000_0000; B = 48'h8000_0000_0000; carryin = 1'b0;
    step();
    total++;
    if (Out !== 48'd3 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_0: got %h/%b want 000000000003/0", Out, carryout);
    end
    A = 48'd5; B = 48'd5; carryin = 1'b1;
    step();
    total++;
    if (Out !== 48'd0 || carryout !== 1'b1) begin
      bad++;
      $display("FAIL b2b_1: got %h/%b want 000000000000/1", Out, carryout);
    end
    A = 48'd0; B = 48'd0; carryin = 1'b0;
    step();
    total++;
    if (Out !== 48'd11 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_2: got %h/%b want 00000000000b/0", Out, carryout);
    end
  endtask

  task automatic test_midflight_reset();
    A = 48'hFFFF_FFFF_FFFF; B = 48'hFFFF_FFFF_FFFF; carryin = 1'b1;
    step();
    A = 48'h0000_00FF_FFFF; B = 48'd1; carryin = 1'b0;
    step();
    // Both stages now hold non-zero sums; reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (Out !== 48'h0 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got %h/%b want 000000000000/0", Out, carryout);
    end
    #2;
    rst_n = 1'b1;
    A = 48'd100; B = 48'd23; carryin = 1'b1;
    step();
    total++;
    if (Out !== 48'h0 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_stale: got %h/%b want 000000000000/0", Out, carryout);
    end
    step();
    total++;
    if (Out !== 48'd124 || carryout !== 1'b0) begin
      bad++;
      $display("FAIL midreset_resume: got %h/%b want 00000000007c/0", Out, carryout);
    end
  endtask

  task automatic test_random();
    logic [48:0] d1, d2, ref_sum;
    logic [47:0] ra, rb;
    logic        rc;
    int          nbad;
    nbad = 0;
    d1 = '0;
    d2 = '0;
    for (int i = 0; i < 10002; i++) begin
      if (i >= 2) begin
        total++;
        if ({carryout, Out} !== d2) begin
          bad++;
          nbad++;
          if (nbad <= 10) begin
            $display("FAIL random_%0d: got %b/%h want %b/%h", i - 2, carryout, Out,
                     d2[48], d2[47:0]);
          end
        end
      end
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(1));
      // Bias some vectors toward long carry chains.
      if ($urandom_range(7) == 0) rb = ~ra;
      ref_sum = {1'b0, ra} + {1'b0, rb} + {48'h0, rc};
      d2 = d1;
      d1 = ref_sum;
      A = ra; B = rb; carryin = rc;
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_midflight_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dsp_48add
